// File: rtl/rvb_dout_fifo_if.sv
// rvb_dout_fifo_if: result handshakes between rvb_full worker, dout buffer and consumer
interface rvb_dout_fifo_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          in_rd;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_rd;
  logic [$clog2(DEPTH):0]   count;
  modport slave (input in_valid, in_rd, out_ready, output in_ready, out_valid, out_rd, count);
  modport master (output in_valid, in_rd, out_ready, input in_ready, out_valid, out_rd, count);
endinterface

// File: rtl/rvb_dout_fifo.sv
// rvb_dout_fifo: in-order result buffer after rvb_full; RVB_DOUT_FIFO_BYPASS_EN adds zero-latency pass-through when empty
module rvb_dout_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  rvb_dout_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW:0]     wp, rp;
  logic            empty, full, push, pop;
  assign empty        = wp == rp;
  assign full         = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign bus.in_ready = !full;
  assign bus.count    = wp - rp;
`ifdef RVB_DOUT_FIFO_BYPASS_EN
  logic byp;
  // an empty buffer forwards the offered result; if taken at once nothing is stored
  assign byp           = empty && bus.in_valid && bus.out_ready;
  assign bus.out_valid = !empty || bus.in_valid;
  assign bus.out_rd    = empty ? bus.in_rd : mem[rp[AW-1:0]];
  assign push          = bus.in_valid && !full && !byp;
`else
  assign bus.out_valid = !empty;
  assign bus.out_rd    = mem[rp[AW-1:0]];
  assign push          = bus.in_valid && !full;
`endif
  assign pop = !empty && bus.out_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (push && !reset) mem[wp[AW-1:0]] <= bus.in_rd;
  end
endmodule

// File: tb/tb_rvb_dout_fifo.sv
// tb_rvb_dout_fifo: directed checks of fill/drain, full+pop, wrap, bypass and mid-run reset
module tb_rvb_dout_fifo;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  rvb_dout_fifo_if #(.XLEN(32), .DEPTH(4)) bus ();
  rvb_dout_fifo #(.XLEN(32), .DEPTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clock);
  endtask
  logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rd = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_rd = vals[i];
      step();
      #1;
      chk($sformatf("fill_count%0d", i), 32'(bus.count), 32'(i + 1));
    end
    bus.in_rd = 32'h55;
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_out_valid", 32'(bus.out_valid), 1);
    chk("full_head", bus.out_rd, 32'h11);
    step();
    #1;
    chk("full_refuse_count", 32'(bus.count), 4);
    bus.out_ready = 1'b1;
    #1;
    chk("pop_head11", bus.out_rd, 32'h11);
    step();
    #1;
    chk("full_pop_count", 32'(bus.count), 3);
    chk("in_ready_rise", 32'(bus.in_ready), 1);
    chk("pop_head22", bus.out_rd, 32'h22);
    step();
    #1;
    bus.in_valid = 1'b0;
    #1;
    chk("pushpop_count", 32'(bus.count), 3);
    chk("pop_head33", bus.out_rd, 32'h33);
    step();
    #1;
    chk("pop_head44", bus.out_rd, 32'h44);
    step();
    #1;
    chk("pop_head55", bus.out_rd, 32'h55);
    chk("drain_count1", 32'(bus.count), 1);
    step();
    #1;
    chk("drained_valid", 32'(bus.out_valid), 0);
    chk("drained_count", 32'(bus.count), 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_rd = 32'd1;
    step();
    #1;
    chk("wrap_first_count", 32'(bus.count), 1);
    bus.out_ready = 1'b1;
    for (int v = 2; v <= 10; v++) begin
      bus.in_rd = 32'(v);
      #1;
      chk($sformatf("wrap_out%0d", v - 1), bus.out_rd, 32'(v - 1));
      chk($sformatf("wrap_count%0d", v), 32'(bus.count), 1);
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("wrap_out10", bus.out_rd, 32'd10);
    step();
    #1;
    chk("wrap_empty", 32'(bus.count), 0);
    bus.in_valid = 1'b1;
    bus.in_rd = 32'hDEADBEEF;
    bus.out_ready = 1'b1;
    #1;
`ifdef RVB_DOUT_FIFO_BYPASS_EN
    chk("byp_valid", 32'(bus.out_valid), 1);
    chk("byp_rd", bus.out_rd, 32'hDEADBEEF);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("byp_count", 32'(bus.count), 0);
    chk("byp_after_valid", 32'(bus.out_valid), 0);
`else
    chk("nobyp_valid0", 32'(bus.out_valid), 0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("nobyp_valid1", 32'(bus.out_valid), 1);
    chk("nobyp_rd", bus.out_rd, 32'hDEADBEEF);
    step();
    #1;
    chk("nobyp_count", 32'(bus.count), 0);
`endif
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_rd = 32'hA1 + 32'(i);
      step();
    end
    #1;
    chk("mid_count3", 32'(bus.count), 3);
    reset = 1'b1;
    bus.in_rd = 32'h99;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    bus.in_rd = 32'h77;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_valid", 32'(bus.out_valid), 1);
    chk("post_rst_rd", bus.out_rd, 32'h77);
    chk("post_rst_count", 32'(bus.count), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvb_dout_fifo.md
# rvb_dout_fifo

Result buffer directly downstream of the `rvb_full` bit-manipulation worker. It accepts `rd` results on a valid/ready handshake and holds up to DEPTH of them in order. It presents them to the consumer (core writeback, or a PCPI-style adapter) on a second valid/ready handshake. This decouples the worker from writeback stalls, so the worker's `dout_ready` no longer has to be tied high.

## Interface
- `XLEN`, 32: result width in bits; 32 or 64.
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: a result is offered; connects to the worker's `dout_valid`.
- `in_ready`  out  1: the buffer accepts a result this cycle; connects to the worker's `dout_ready`.
- `in_rd`  in  XLEN: result data.
- `out_valid`  out  1: the head entry is available.
- `out_ready`  in  1: the consumer takes the head entry.
- `out_rd`  out  XLEN: head entry data.
- `count`  out  $clog2(DEPTH)+1: number of entries currently stored.

## Operation
- Storage is a circular array `mem[DEPTH]`.
- The write pointer `wp` and read pointer `rp` are each $clog2(DEPTH)+1 bits. The extra MSB is the wrap bit, and the pointers wrap naturally modulo 2·DEPTH.
- Index into `mem` with the pointer's low bits.
- Empty when `wp == rp`. Full when the low bits are equal and the MSBs differ.
- `count = wp - rp`, computed modulo 2^($clog2(DEPTH)+1).
- Push: fires when `in_valid && in_ready`. It writes `mem[wp] <= in_rd` and increments `wp`.
- Pop: fires when `out_valid && out_ready`. It increments `rp`.
- `in_ready = !full`. This depends on registered state only and never on `out_ready`, so there is no combinational path from `out_ready` to `in_ready`.
- `out_valid = !empty`, and `out_rd = mem[rp]`.
- When the buffer is full, a push is refused even if a pop fires in the same cycle. `in_ready` rises on the cycle after the pop.
- A simultaneous push and pop on a non-empty, non-full buffer leaves `count` unchanged, and both pointers advance.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- Handshake rules:
  - The upstream side holds `in_valid` and `in_rd` stable until accepted.
  - The buffer guarantees `out_valid` and `out_rd` stay stable until popped.
  - `out_valid` never falls without a pop.
- `mem` contents are not reset. Unused entries are don't-care, and `out_rd` is unspecified whenever `out_valid` is 0.

## Timing
- Reset values take effect at the first rising edge with `reset` high:
  - `wp` = 0, `rp` = 0, `count` = 0
  - `out_valid` = 0, `in_ready` = 1
- While `reset` is high, pushes and pops have no effect and the reset state is held.
- Asserting `reset` mid-operation discards all stored entries in the next cycle.
- Latency without bypass: a result pushed on edge N is visible with `out_valid = 1` during cycle N+1, and can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained.
- With `out_ready` permanently high, throughput is 1 result per cycle, and occupancy never exceeds 1.

## Configuration
- Macro: `RVB_DOUT_FIFO_BYPASS_EN`.
- When defined, the buffer behaves as follows when empty:
  - `out_valid = in_valid` and `out_rd = in_rd` combinationally.
  - If `out_ready` is also high, the handshake completes in the same cycle with zero latency. Nothing is written and neither pointer moves.
  - If `out_ready` is low, the result is pushed normally, and `out_valid` stays high from the next cycle onward from storage.
  - Side effect: `out_valid` depends combinationally on `in_valid` when empty.
- When not defined, there is no combinational path from input to output, and the minimum latency is one cycle as described in Timing.
- `in_ready` is identical in both builds.

## Test plan
- **Reset:** hold `reset` 2 cycles, then release with `in_valid = 0` → `count = 0`, `out_valid = 0`, `in_ready = 1`.
- **Fill and drain (DEPTH = 4):**
  - Push 0x11, 0x22, 0x33, 0x44 with `out_ready = 0` → `count` goes 1, 2, 3, 4, and `in_ready = 0` after the 4th push.
  - Offer 0x55 → it is not accepted.
  - Set `out_ready = 1` → `out_rd` sequence is 0x11, 0x22, 0x33, 0x44, then 0x55 is accepted once `in_ready` rises.
- **Full with a simultaneous pop:** while full, assert `in_valid` and `out_ready` → the pop fires, the push is refused, `count` goes 4→3, and the next cycle's push is accepted.
- **Wrap-around:** perform 10 push/pop pairs of values 1..10 at occupancy 1–2 → values are output in order 1..10 with no loss, and `count` never exceeds 2.
- **Bypass:**
  - With `RVB_DOUT_FIFO_BYPASS_EN` and an empty buffer, drive `in_valid = 1`, `in_rd = 0xDEADBEEF`, `out_ready = 1` → in the same cycle `out_valid = 1` and `out_rd = 0xDEADBEEF`, with `count` staying 0.
  - Without the macro → `out_valid` is 0 in that cycle, and 1 with 0xDEADBEEF in the next cycle.
- **Reset mid-run:** with 3 entries stored, assert `reset` for 1 cycle → `count = 0` and `out_valid = 0` the following cycle, and the next push of 0x77 is the first value output.
